id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32I core; sits directly downstream of control_unit and the register file/immediate generator in ID, and feeds the EX stage.
- Captures the decoded control bundle, operands, immediate, PC and register addresses each cycle.
- Supports stall (hold), flush (bubble) and built-in load-use hazard detection. On a hazard it asserts a stall request to IF/ID and PC, and inserts a bubble.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_stall  in  1  downstream hold request (e.g. DMEM wait); register keeps its contents.
- i_flush  in  1  branch/jump taken in EX; kill the instruction entering from ID.
- i_pc  in  XLEN  PC of the ID instruction.
- i_inst  in  32  ID instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], opcode=[6:0].
- i_rs1_data, i_rs2_data  in  XLEN  register file read data.
- i_imm  in  XLEN  immediate generator output.
- i_insn_vld_ctrl, i_rd_wren, i_br_un, i_bsel, i_asel, i_wren  in  1 each  control_unit outputs.
- i_alu_op  in  4  control_unit ALU op.
- i_slt_sl  in  3  control_unit load/store select.
- i_wb_sel  in  2  control_unit writeback select.
- o_pc, o_rs1_data, o_rs2_data, o_imm  out  XLEN  registered copies.
- o_rd_addr, o_rs1_addr, o_rs2_addr  out  5  registered register addresses.
- o_funct3  out  3  registered funct3, used by the EX branch comparator.
- o_opcode  out  7  registered opcode.
- o_insn_vld, o_rd_wren, o_br_un, o_bsel, o_asel, o_wren  out  1 each  registered control.
- o_alu_op  out  4  registered control.
- o_slt_sl  out  3  registered control.
- o_wb_sel  out  2  registered control.
- o_hazard_stall  out  1  combinational load-use stall request to the PC and IF/ID registers.

Behaviour:
- Reset: while i_reset=1, asynchronously clear every registered output to 0. This equals a bubble: o_insn_vld=0, o_rd_wren=0, o_wren=0.
- Bubble content: all registered outputs 0.
- Latency: 1 cycle. Outputs show the ID values captured at the previous rising edge.
- Load-use detect (combinational from current registered state and i_inst):
  - EX is a load when o_insn_vld=1, o_rd_wren=1, o_wb_sel=2'b00 and o_rd_addr!=0.
  - ID uses rs1 when opcode is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - ID uses rs2 when opcode is one of 0110011, 0100011, 1100011.
  - o_hazard_stall = EX-is-load AND i_insn_vld_ctrl AND ((uses rs1 AND rs1==o_rd_addr) OR (uses rs2 AND rs2==o_rd_addr)).
  - x0 never causes a hazard.
- Next-state priority at each rising edge, highest first:
  1. i_flush=1: load bubble. Flush overrides i_stall and the hazard.
  2. i_stall=1: hold all contents. o_hazard_stall stays valid because state is unchanged.
  3. o_hazard_stall=1: load bubble. Upstream holds the ID instruction, so it is re-presented next cycle and, with the hazard now cleared, captured.
  4. Otherwise: capture all ID inputs. o_insn_vld takes i_insn_vld_ctrl.
- An instruction with i_insn_vld_ctrl=0 is captured as-is. Its o_rd_wren and o_wren are already 0 from control_unit and are never forced high.
- Reset asserted mid-operation: contents clear immediately. The first edge after reset deasserts follows the normal priority.
- No internal state other than the pipeline register. No FSM beyond the capture/hold/bubble select.

Test Plan:
- Reset: i_reset=1 with nonzero inputs -> all outputs 0 asynchronously, before any clock edge. After release, one edge with ADDI x5,x0,7 -> o_rd_addr=5, o_imm=7, o_bsel=1, o_rd_wren=1, o_insn_vld=1.
- Load-use: LW x3,0(x1) captured, then ID=ADD x4,x3,x2 -> o_hazard_stall=1 that cycle. Next edge loads bubble (o_insn_vld=0, o_rd_wren=0). ADD re-presented -> o_hazard_stall=0 and captured on the following edge.
- No false hazard: LW x0,0(x1) followed by ADD x4,x0,x0 -> o_hazard_stall=0. LW x3 followed by LUI x3,0x12345 -> o_hazard_stall=0. LW x3 followed by ADDI x4,x1,3 with rs2 field=3 -> o_hazard_stall=0.
- Flush priority: i_flush=1, i_stall=1 and a load-use hazard all active together -> after the edge, outputs equal a bubble and o_wren=0.
- Stall hold: SW captured, i_stall=1 for 3 cycles while ID inputs change -> o_wren=1, o_slt_sl=3'b010 and o_imm unchanged for all 3 cycles. The next instruction is captured on the first edge after i_stall drops.
- Branch fields: BNE x1,x2,-8 at PC=0x40 -> o_funct3=3'b001, o_opcode=1100011, o_asel=1, o_imm=0xFFFFFFF8, o_pc=0x40, o_rd_wren=0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core. It carries the decoded
// instruction into EX and raises a load-use stall request toward IF/ID and PC.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_insn_vld_ctrl,
    input  logic            i_rd_wren,
    input  logic            i_br_un,
    input  logic            i_bsel,
    input  logic            i_asel,
    input  logic            i_wren,
    input  logic [3:0]      i_alu_op,
    input  logic [2:0]      i_slt_sl,
    input  logic [1:0]      i_wb_sel,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rd_addr,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_opcode,
    output logic            o_insn_vld,
    output logic            o_rd_wren,
    output logic            o_br_un,
    output logic            o_bsel,
    output logic            o_asel,
    output logic            o_wren,
    output logic [3:0]      o_alu_op,
    output logic [2:0]      o_slt_sl,
    output logic [1:0]      o_wb_sel,
    output logic            o_hazard_stall
);

    logic [XLEN-1:0] r_pc_p1, r_rs1_data_p1, r_rs2_data_p1, r_imm_p1;
    logic [4:0]      r_rd_addr_p1, r_rs1_addr_p1, r_rs2_addr_p1;
    logic [2:0]      r_funct3_p1;
    logic [6:0]      r_opcode_p1;
    logic            r_vld_p1, r_rd_wren_p1, r_br_un_p1, r_bsel_p1, r_asel_p1, r_wren_p1;
    logic [3:0]      r_alu_op_p1;
    logic [2:0]      r_slt_sl_p1;
    logic [1:0]      r_wb_sel_p1;

    logic [6:0] w_id_opcode;
    logic [4:0] w_id_rs1, w_id_rs2;
    logic       w_uses_rs1, w_uses_rs2, w_ex_is_load, w_hazard, w_bubble;

    assign w_id_opcode = i_inst[6:0];
    assign w_id_rs1    = i_inst[19:15];
    assign w_id_rs2    = i_inst[24:20];

    always_comb begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (w_id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: w_uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    // wb_sel 00 selects load data; rd=x0 results are discarded so never stall
    assign w_ex_is_load = r_vld_p1 & r_rd_wren_p1 & (r_wb_sel_p1 == 2'b00)
                        & (r_rd_addr_p1 != 5'd0);
    assign w_hazard = w_ex_is_load & i_insn_vld_ctrl
                    & ((w_uses_rs1 & (w_id_rs1 == r_rd_addr_p1))
                     | (w_uses_rs2 & (w_id_rs2 == r_rd_addr_p1)));

    // Flush beats stall; a hazard only bubbles when the register is free to move
    assign w_bubble = i_flush | (~i_stall & w_hazard);

    // ID -> EX stage boundary
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || w_bubble) begin
            r_pc_p1       <= '0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_imm_p1      <= '0;
            r_rd_addr_p1  <= '0;
            r_rs1_addr_p1 <= '0;
            r_rs2_addr_p1 <= '0;
            r_funct3_p1   <= '0;
            r_opcode_p1   <= '0;
            r_vld_p1      <= 1'b0;
            r_rd_wren_p1  <= 1'b0;
            r_br_un_p1    <= 1'b0;
            r_bsel_p1     <= 1'b0;
            r_asel_p1     <= 1'b0;
            r_wren_p1     <= 1'b0;
            r_alu_op_p1   <= '0;
            r_slt_sl_p1   <= '0;
            r_wb_sel_p1   <= '0;
        end else if (!i_stall) begin
            r_pc_p1       <= i_pc;
            r_rs1_data_p1 <= i_rs1_data;
            r_rs2_data_p1 <= i_rs2_data;
            r_imm_p1      <= i_imm;
            r_rd_addr_p1  <= i_inst[11:7];
            r_rs1_addr_p1 <= w_id_rs1;
            r_rs2_addr_p1 <= w_id_rs2;
            r_funct3_p1   <= i_inst[14:12];
            r_opcode_p1   <= w_id_opcode;
            r_vld_p1      <= i_insn_vld_ctrl;
            r_rd_wren_p1  <= i_rd_wren;
            r_br_un_p1    <= i_br_un;
            r_bsel_p1     <= i_bsel;
            r_asel_p1     <= i_asel;
            r_wren_p1     <= i_wren;
            r_alu_op_p1   <= i_alu_op;
            r_slt_sl_p1   <= i_slt_sl;
            r_wb_sel_p1   <= i_wb_sel;
        end
    end

    assign o_pc           = r_pc_p1;
    assign o_rs1_data     = r_rs1_data_p1;
    assign o_rs2_data     = r_rs2_data_p1;
    assign o_imm          = r_imm_p1;
    assign o_rd_addr      = r_rd_addr_p1;
    assign o_rs1_addr     = r_rs1_addr_p1;
    assign o_rs2_addr     = r_rs2_addr_p1;
    assign o_funct3       = r_funct3_p1;
    assign o_opcode       = r_opcode_p1;
    assign o_insn_vld     = r_vld_p1;
    assign o_rd_wren      = r_rd_wren_p1;
    assign o_br_un        = r_br_un_p1;
    assign o_bsel         = r_bsel_p1;
    assign o_asel         = r_asel_p1;
    assign o_wren         = r_wren_p1;
    assign o_alu_op       = r_alu_op_p1;
    assign o_slt_sl       = r_slt_sl_p1;
    assign o_wb_sel       = r_wb_sel_p1;
    assign o_hazard_stall = w_hazard;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed RV32I scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_reg;

    logic        clk, rst, stall, flush;
    logic [31:0] pc, inst, rs1d, rs2d, imm;
    logic        vld, rdw, brun, bsel, asel, wren;
    logic [3:0]  alu;
    logic [2:0]  slt;
    logic [1:0]  wb;

    logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]  o_rd_addr, o_rs1_addr, o_rs2_addr;
    logic [2:0]  o_funct3;
    logic [6:0]  o_opcode;
    logic        o_insn_vld, o_rd_wren, o_br_un, o_bsel, o_asel, o_wren, o_hazard_stall;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_slt_sl;
    logic [1:0]  o_wb_sel;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    id_ex_reg #(.XLEN(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_pc(pc), .i_inst(inst), .i_rs1_data(rs1d), .i_rs2_data(rs2d), .i_imm(imm),
        .i_insn_vld_ctrl(vld), .i_rd_wren(rdw), .i_br_un(brun), .i_bsel(bsel),
        .i_asel(asel), .i_wren(wren), .i_alu_op(alu), .i_slt_sl(slt), .i_wb_sel(wb),
        .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
        .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .o_funct3(o_funct3), .o_opcode(o_opcode), .o_insn_vld(o_insn_vld),
        .o_rd_wren(o_rd_wren), .o_br_un(o_br_un), .o_bsel(o_bsel), .o_asel(o_asel),
        .o_wren(o_wren), .o_alu_op(o_alu_op), .o_slt_sl(o_slt_sl), .o_wb_sel(o_wb_sel),
        .o_hazard_stall(o_hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the EX-stage instruction as a record of named fields
    typedef struct {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [31:0] inst;
        logic        vld, rdw, brun, bsel, asel, wren;
        logic [3:0]  alu;
        logic [2:0]  slt;
        logic [1:0]  wb;
    } ex_t;

    ex_t m;

    function automatic ex_t bubble();
        ex_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic logic model_hazard(ex_t ex, logic [31:0] id_inst, logic id_vld);
        logic [4:0] rd;
        logic ex_load, u1, u2;
        rd = ex.inst[11:7];
        ex_load = ex.vld && ex.rdw && (ex.wb == 2'b00) && (rd != 5'd0);
        u1 = id_inst[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        u2 = id_inst[6:0] inside {7'h33, 7'h23, 7'h63};
        return ex_load && id_vld &&
               ((u1 && id_inst[19:15] == rd) || (u2 && id_inst[24:20] == rd));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= bubble();
        else if (flush) m <= bubble();
        else if (stall) m <= m;
        else if (model_hazard(m, inst, vld)) m <= bubble();
        else m <= '{pc: pc, rs1d: rs1d, rs2d: rs2d, imm: imm, inst: inst, vld: vld,
                    rdw: rdw, brun: brun, bsel: bsel, asel: asel, wren: wren,
                    alu: alu, slt: slt, wb: wb};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Every cycle, mid-period, compare all outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("pc", o_pc, m.pc);
            chk("rs1_data", o_rs1_data, m.rs1d);
            chk("rs2_data", o_rs2_data, m.rs2d);
            chk("imm", o_imm, m.imm);
            chk("fields", {7'd0, o_rd_addr, o_rs1_addr, o_rs2_addr, o_funct3, o_opcode},
                {7'd0, m.inst[11:7], m.inst[19:15], m.inst[24:20], m.inst[14:12], m.inst[6:0]});
            chk("ctrl", {17'd0, o_insn_vld, o_rd_wren, o_br_un, o_bsel, o_asel, o_wren,
                         o_alu_op, o_slt_sl, o_wb_sel},
                {17'd0, m.vld, m.rdw, m.brun, m.bsel, m.asel, m.wren, m.alu, m.slt, m.wb});
            chk("hazard", {31'd0, o_hazard_stall}, {31'd0, model_hazard(m, inst, vld)});
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] p, input logic [31:0] in, input logic [31:0] im,
                          input logic rw, input logic bs, input logic as, input logic wr,
                          input logic [2:0] sl, input logic [1:0] ws);
        pc = p; inst = in; imm = im; vld = 1'b1; rdw = rw; bsel = bs; asel = as;
        wren = wr; slt = sl; wb = ws; brun = 1'b0;
        rs1d = $urandom; rs2d = $urandom; alu = 4'($urandom);
    endtask

    task automatic rand_id();
        logic [6:0] ops [9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h6F, 7'h17};
        inst = $urandom;
        inst[6:0]   = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        inst[11:7]  = 5'($urandom_range(0, 3));
        inst[19:15] = 5'($urandom_range(0, 3));
        inst[24:20] = 5'($urandom_range(0, 3));
        pc = $urandom; rs1d = $urandom; rs2d = $urandom; imm = $urandom;
        vld = ($urandom_range(0, 7) != 0);
        rdw = vld & 1'($urandom); wren = vld & 1'($urandom);
        brun = 1'($urandom); bsel = 1'($urandom); asel = 1'($urandom);
        alu = 4'($urandom); slt = 3'($urandom); wb = 2'($urandom);
    endtask

    localparam logic [31:0] ADDI_X5 = 32'h0070_0293;
    localparam logic [31:0] LW_X3   = 32'h0000_A183;
    localparam logic [31:0] ADD_X4  = 32'h0021_8233;
    localparam logic [31:0] LW_X0   = 32'h0000_A003;
    localparam logic [31:0] ADD_X0  = 32'h0000_0233;
    localparam logic [31:0] LUI_X3  = 32'h1234_51B7;
    localparam logic [31:0] ADDI_X4 = 32'h0030_8213;
    localparam logic [31:0] SW_X2   = 32'h0020_A223;
    localparam logic [31:0] BNE_M8  = 32'hFE20_9CE3;

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(32'h1234, ADD_X4, 32'hDEAD, 1, 1, 1, 1, 3'b111, 2'b11);
        #1 rst = 1'b1;
        #2;
        chk("reset_pc", o_pc, 32'h0);
        chk("reset_imm", o_imm, 32'h0);
        chk("reset_ctrl", {29'd0, o_insn_vld, o_rd_wren, o_wren}, 32'h0);
        chk("reset_rd", {27'd0, o_rd_addr}, 32'h0);

        edge1();
        rst = 1'b0;
        set_id(32'h0, ADDI_X5, 32'd7, 1, 1, 0, 0, 3'b000, 2'b01);
        edge1();
        chk("addi_rd", {27'd0, o_rd_addr}, 32'd5);
        chk("addi_imm", o_imm, 32'd7);
        chk("addi_ctrl", {29'd0, o_bsel, o_rd_wren, o_insn_vld}, 32'h7);

        set_id(32'h4, LW_X3, 32'd0, 1, 1, 0, 0, 3'b010, 2'b00);
        edge1();
        set_id(32'h8, ADD_X4, 32'd0, 1, 0, 0, 0, 3'b000, 2'b01);
        #1 chk("lu_hazard", {31'd0, o_hazard_stall}, 32'd1);
        edge1();
        chk("lu_bubble", {30'd0, o_insn_vld, o_rd_wren}, 32'd0);
        chk("lu_cleared", {31'd0, o_hazard_stall}, 32'd0);
        edge1();
        chk("lu_capture", {22'd0, o_insn_vld, o_rd_addr, o_rs1_addr}, {22'd0, 1'b1, 5'd4, 5'd3});

        set_id(32'hC, LW_X0, 32'd0, 1, 1, 0, 0, 3'b010, 2'b00);
        edge1();
        set_id(32'h10, ADD_X0, 32'd0, 1, 0, 0, 0, 3'b000, 2'b01);
        #1 chk("x0_nohaz", {31'd0, o_hazard_stall}, 32'd0);
        set_id(32'h10, LW_X3, 32'd0, 1, 1, 0, 0, 3'b010, 2'b00);
        edge1();
        set_id(32'h14, LUI_X3, 32'h1234_5000, 1, 1, 0, 0, 3'b000, 2'b01);
        #1 chk("lui_nohaz", {31'd0, o_hazard_stall}, 32'd0);
        set_id(32'h14, ADDI_X4, 32'd3, 1, 1, 0, 0, 3'b000, 2'b01);
        #1 chk("addi_rs2_nohaz", {31'd0, o_hazard_stall}, 32'd0);

        set_id(32'h14, ADD_X4, 32'd0, 1, 0, 0, 0, 3'b000, 2'b01);
        flush = 1'b1; stall = 1'b1;
        #1 chk("flush_haz_active", {31'd0, o_hazard_stall}, 32'd1);
        edge1();
        chk("flush_bubble", {29'd0, o_insn_vld, o_rd_wren, o_wren}, 32'd0);
        chk("flush_data", o_pc | o_imm | {27'd0, o_rd_addr}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        set_id(32'h20, SW_X2, 32'd4, 0, 1, 0, 1, 3'b010, 2'b00);
        edge1();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_id();
            edge1();
            chk("stall_hold", {o_imm[23:0], 4'd0, o_wren, o_slt_sl}, {24'd4, 4'd0, 1'b1, 3'b010});
        end
        stall = 1'b0;
        set_id(32'h24, ADDI_X5, 32'd7, 1, 1, 0, 0, 3'b000, 2'b01);
        edge1();
        chk("post_stall", {26'd0, o_wren, o_rd_addr}, {26'd0, 1'b0, 5'd5});

        set_id(32'h40, BNE_M8, 32'hFFFF_FFF8, 0, 1, 1, 0, 3'b000, 2'b00);
        edge1();
        chk("bne_fields", {20'd0, o_funct3, o_opcode, o_asel, o_rd_wren},
            {20'd0, 3'b001, 7'b1100011, 1'b1, 1'b0});
        chk("bne_imm", o_imm, 32'hFFFF_FFF8);
        chk("bne_pc", o_pc, 32'h40);

        for (int i = 0; i < 3000; i++) begin
            rand_id();
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 6) == 0);
            if (i == 1500) begin
                #1 rst = 1'b1;
                #1 chk("midrun_reset", {o_pc[15:0], 13'd0, o_insn_vld, o_rd_wren, o_wren}, 32'd0);
                #1 rst = 1'b0;
            end
            edge1();
        end
        flush = 1'b0; stall = 1'b0;
        edge1();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
